// File: rtl/mem_image_loader.sv
// mem_image_loader: parses a little-endian byte frame {base, N, 4*N data, xor csum} and writes it to memory as 32-bit words
// Latency: one byte accepted per cycle outside WRITE; each word adds a WRITE cycle (>=5 cycles/word); done/error one cycle after csum byte
// Backpressure: o_byte_ready low in IDLE/WRITE/DONE/ERROR; WRITE holds addr/wdata stable until i_mem_ready
// Ports: i_clk/i_rst (sync, active-high); i_start pulse; i_byte/i_byte_valid/o_byte_ready byte stream;
//        o_mem_we/o_mem_addr/o_mem_wdata/i_mem_ready word write port; o_cpu_hold, o_done, o_error, o_words_written status.
// Build option: define LOADER_RANGE_CHECK_EN to reject frames whose [base, base+4*N) leaves [MEM_BASE, MEM_BASE+MEM_SIZE).
module mem_image_loader #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] MEM_BASE = 32'h0000_0000,
  parameter logic [XLEN-1:0] MEM_SIZE = 32'h0001_0000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [7:0]      i_byte,
  input  logic            i_byte_valid,
  output logic            o_byte_ready,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic            i_mem_ready,
  output logic            o_cpu_hold,
  output logic            o_done,
  output logic            o_error,
  output logic [XLEN-1:0] o_words_written
);

`ifdef LOADER_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  // One spare bit beyond base + 4*N so the end-address sum itself cannot wrap.
  localparam int RW = XLEN + 3;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t          r_state, w_next;
  logic [1:0]      r_idx;
  logic [XLEN-1:0] r_addr, r_wdata, r_len, r_words;
  logic [7:0]      r_csum;
  logic            r_done, r_error;

  logic            w_xfer, w_last, w_start_ok, w_reject, w_range_bad;
  logic [XLEN-1:0] w_len_full;
  logic [RW-1:0]   w_end, w_limit;

  assign w_xfer     = i_byte_valid & o_byte_ready;
  assign w_last     = (r_idx == 2'd3);
  assign w_start_ok = i_start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERROR));
  // Full word count as it stands once the 4th LEN byte arrives.
  assign w_len_full = {i_byte, r_len[XLEN-9:0]};

  assign w_end       = {3'b000, r_addr} + {1'b0, w_len_full, 2'b00};
  assign w_limit     = {3'b000, MEM_BASE} + {3'b000, MEM_SIZE};
  assign w_range_bad = (r_addr < MEM_BASE) | (w_end > w_limit);
  assign w_reject    = RANGE_EN & w_range_bad;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_ADDR;
      S_ADDR:  if (w_xfer && w_last) w_next = S_LEN;
      S_LEN:   if (w_xfer && w_last) begin
                 if (w_reject)               w_next = S_ERROR;
                 else if (w_len_full == '0)  w_next = S_CSUM;
                 else                        w_next = S_DATA;
               end
      S_DATA:  if (w_xfer && w_last) w_next = S_WRITE;
      S_WRITE: if (i_mem_ready) w_next = (r_len == XLEN'(1)) ? S_CSUM : S_DATA;
      S_CSUM:  if (w_xfer) w_next = (i_byte == r_csum) ? S_DONE : S_ERROR;
      S_DONE, S_ERROR: if (i_start) w_next = S_ADDR;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    o_byte_ready = 1'b0;
    o_mem_we     = 1'b0;
    o_cpu_hold   = 1'b0;
    case (r_state)
      S_ADDR, S_LEN, S_DATA, S_CSUM: begin
        o_byte_ready = 1'b1;
        o_cpu_hold   = 1'b1;
      end
      S_WRITE: begin
        o_mem_we   = 1'b1;
        o_cpu_hold = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: field assembly, checksum, write bookkeeping, sticky status
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_len   <= '0;
      r_words <= '0;
      r_csum  <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
        r_words <= '0;
        r_idx   <= '0;
        r_csum  <= '0;
      end
      case (r_state)
        S_ADDR: if (w_xfer) begin
          // Force word alignment as the lowest byte lands.
          r_addr[{r_idx, 3'b000} +: 8] <= (r_idx == 2'd0) ? (i_byte & 8'hFC) : i_byte;
          r_idx <= r_idx + 2'd1;
        end
        S_LEN: if (w_xfer) begin
          r_len[{r_idx, 3'b000} +: 8] <= i_byte;
          r_idx <= r_idx + 2'd1;
          if (w_last && w_reject) r_error <= 1'b1;
        end
        S_DATA: if (w_xfer) begin
          r_wdata[{r_idx, 3'b000} +: 8] <= i_byte;
          r_csum <= r_csum ^ i_byte;
          r_idx  <= r_idx + 2'd1;
        end
        S_WRITE: if (i_mem_ready) begin
          r_words <= r_words + XLEN'(1);
          r_addr  <= r_addr + XLEN'(4);
          r_len   <= r_len - XLEN'(1);
        end
        S_CSUM: if (w_xfer) begin
          if (i_byte == r_csum) r_done  <= 1'b1;
          else                  r_error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_mem_addr      = r_addr;
  assign o_mem_wdata     = r_wdata;
  assign o_done          = r_done;
  assign o_error         = r_error;
  assign o_words_written = r_words;

endmodule

// File: tb/tb_mem_image_loader.sv
module tb_mem_image_loader;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_byte_valid, i_mem_ready;
  logic [7:0]  i_byte;
  logic        o_byte_ready, o_mem_we, o_cpu_hold, o_done, o_error;
  logic [31:0] o_mem_addr, o_mem_wdata, o_words_written;

  always #5 clk = ~clk;

  mem_image_loader dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
    .i_byte(i_byte), .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ready(i_mem_ready), .o_cpu_hold(o_cpu_hold), .o_done(o_done),
    .o_error(o_error), .o_words_written(o_words_written)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Memory model: log every accepted write.
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  always @(posedge clk) begin
    if (o_mem_we && i_mem_ready) begin
      wr_addr_q.push_back(o_mem_addr);
      wr_data_q.push_back(o_mem_wdata);
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  csum;
    logic        exp_done;
    logic        exp_err;
    logic [31:0] exp_end_addr;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    i_byte       = b;
    i_byte_valid = 1'b1;
    while (!o_byte_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      n_chk++;
      $display("FAIL byte_wait: o_byte_ready=0 after %0d cycles, required 1", t);
    end
    @(negedge clk);
    i_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic start_frame(input logic [31:0] addr, input logic [31:0] n);
    wr_addr_q.delete();
    wr_data_q.delete();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("hold_after_start", {31'd0, o_cpu_hold}, 32'd1);
    chk("done_cleared", {30'd0, o_done, o_error}, 32'd0);
    send_word(addr);
    send_word(n);
  endtask

  task automatic run_vec(input int i);
    logic [31:0] base;
    logic [31:0] wd;
    base = tbl[i].addr & 32'hFFFF_FFFC;
    start_frame(tbl[i].addr, tbl[i].n);
    if (tbl[i].n > 0) send_word(tbl[i].w0);
    if (tbl[i].n > 1) send_word(tbl[i].w1);
    send_byte(tbl[i].csum);
    chk($sformatf("v%0d_done", i),  {31'd0, o_done},  {31'd0, tbl[i].exp_done});
    chk($sformatf("v%0d_error", i), {31'd0, o_error}, {31'd0, tbl[i].exp_err});
    chk($sformatf("v%0d_hold", i),  {31'd0, o_cpu_hold}, 32'd0);
    chk($sformatf("v%0d_words", i), o_words_written, tbl[i].n);
    chk($sformatf("v%0d_addr", i),  o_mem_addr, tbl[i].exp_end_addr);
    chk($sformatf("v%0d_nwr", i),   wr_addr_q.size(), tbl[i].n);
    for (int k = 0; k < wr_addr_q.size() && k < 2; k++) begin
      wd = (k == 0) ? tbl[i].w0 : tbl[i].w1;
      chk($sformatf("v%0d_wa%0d", i, k), wr_addr_q[k], base + 32'(4 * k));
      chk($sformatf("v%0d_wd%0d", i, k), wr_data_q[k], wd);
    end
  endtask

  initial begin
    //          addr          n  w0            w1            csum   done  err   end addr
    tbl[0] = '{32'h0000_0100, 2, 32'h1234_5678, 32'hDEAD_BEEF, 8'h2A, 1'b1, 1'b0, 32'h0000_0108};
    tbl[1] = '{32'h0000_0100, 2, 32'h1234_5678, 32'hDEAD_BEEF, 8'h9D, 1'b0, 1'b1, 32'h0000_0108};
    tbl[2] = '{32'h0000_0040, 1, 32'h0403_0201, 32'h0,         8'h00, 1'b0, 1'b1, 32'h0000_0044};
    tbl[3] = '{32'h0000_0203, 0, 32'h0,         32'h0,         8'h00, 1'b1, 1'b0, 32'h0000_0200};
    tbl[4] = '{32'h0000_0010, 0, 32'h0,         32'h0,         8'h55, 1'b0, 1'b1, 32'h0000_0010};
    tbl[5] = '{32'hFFFF_FFFC, 1, 32'hA5A5_A5A5, 32'h0,         8'h00, 1'b1, 1'b0, 32'h0000_0000};

    i_rst = 1'b1; i_start = 1'b0; i_byte = 8'h00; i_byte_valid = 1'b0; i_mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, o_byte_ready}, 32'd0);
    chk("rst_flags", {28'd0, o_mem_we, o_cpu_hold, o_done, o_error}, 32'd0);
    chk("rst_addr",  o_mem_addr, 32'd0);
    chk("rst_wdata", o_mem_wdata, 32'd0);
    chk("rst_words", o_words_written, 32'd0);
    i_rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, o_byte_ready}, 32'd0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Write stall: first write held for 7 cycles with a byte offered meanwhile.
    start_frame(32'h0000_0100, 32'd2);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
    i_mem_ready = 1'b0;
    send_byte(8'h12);
    i_byte = 8'hEF; i_byte_valid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      chk($sformatf("bp_we%0d", c),    {31'd0, o_mem_we}, 32'd1);
      chk($sformatf("bp_rdy%0d", c),   {31'd0, o_byte_ready}, 32'd0);
      chk($sformatf("bp_addr%0d", c),  o_mem_addr, 32'h0000_0100);
      chk($sformatf("bp_wdata%0d", c), o_mem_wdata, 32'h1234_5678);
      @(negedge clk);
    end
    chk("bp_nwr_stall", wr_addr_q.size(), 32'd0);
    i_mem_ready = 1'b1;
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    send_byte(8'h2A);
    chk("bp_done",  {30'd0, o_done, o_error}, 32'd2);
    chk("bp_words", o_words_written, 32'd2);
    chk("bp_nwr",   wr_addr_q.size(), 32'd2);
    if (wr_addr_q.size() == 2) begin
      chk("bp_wa0", wr_addr_q[0], 32'h0000_0100);
      chk("bp_wd0", wr_data_q[0], 32'h1234_5678);
      chk("bp_wa1", wr_addr_q[1], 32'h0000_0104);
      chk("bp_wd1", wr_data_q[1], 32'hDEAD_BEEF);
    end

    // Reset after 6 data bytes, then a clean reload.
    start_frame(32'h0000_0300, 32'd2);
    send_word(32'h1122_3344);
    send_byte(8'h55); send_byte(8'h66);
    chk("mid_words", o_words_written, 32'd1);
    chk("mid_hold",  {31'd0, o_cpu_hold}, 32'd1);
    i_rst = 1'b1;
    @(negedge clk);
    chk("mrst_flags", {27'd0, o_byte_ready, o_mem_we, o_cpu_hold, o_done, o_error}, 32'd0);
    chk("mrst_addr",  o_mem_addr, 32'd0);
    chk("mrst_wdata", o_mem_wdata, 32'd0);
    chk("mrst_words", o_words_written, 32'd0);
    i_rst = 1'b0;
    @(negedge clk);
    run_vec(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
